scan_code_sequencer: RTL and testbench
======================================

// Module: scan_code_sequencer
// PURPOSE
//  Upstream stage for the 4-to-16 enable decoder. Generates the code/enable pair the decoder consumes:
//  walks the code space 0..2**WIDTH-1 (or the reverse), holding each code for HOLD clock cycles,
//  then blanks the decoder (en=0) for one hold period.
//  Used for LED/row scanning and for the self-test sweep of the decoder.
// PARAMETERS
//  WIDTH  4   code width; decoder output count is 2**WIDTH
//  HOLD   20  clock cycles each code is held; legal range 1..65535
// PORTS
//  clk         in   1      rising-edge clock
//  rst         in   1      synchronous, active-high reset
//  start       in   1      begin a sweep; sampled only in IDLE
//  stop        in   1      abort the sweep; highest priority
//  continuous  in   1      1 = loop forever, 0 = single sweep; sampled with start
//  dir         in   1      0 = count up (0..LAST), 1 = count down (LAST..0); sampled with start
//  code        out  WIDTH  decoder select input D
//  en          out  1      decoder enable
//  busy        out  1      high in RUN and BLANK
//  done        out  1      one-cycle pulse when a single sweep completes
//  wrap        out  1      one-cycle pulse when a continuous sweep restarts
// BEHAVIOUR
//  - All outputs are registered. Reset: code=0, en=0, busy=0, done=0, wrap=0, FSM=IDLE, hold count=0.
//  - FSM states: IDLE, RUN, BLANK.
//  - IDLE: en=0; code holds its last value.
//    - start=1 and stop=0 at edge k -> from edge k+1: RUN, en=1, busy=1.
//    - First code is 0 (dir=0) or LAST=2**WIDTH-1 (dir=1).
//    - dir and continuous are latched at edge k; later changes are ignored until the next start.
//  - RUN: each code is driven for exactly HOLD cycles, then code steps by +1 (up) or -1 (down).
//    - Terminal code is LAST (up) or 0 (down). After its HOLD cycles:
//      - continuous=1: code wraps to the first code, wrap=1 for that one cycle, en stays 1.
//      - continuous=0: go to BLANK; en=0, code holds the terminal value.
//    - Single sweep = 2**WIDTH * HOLD cycles with en=1.
//  - BLANK: lasts HOLD cycles with en=0. It then returns to IDLE.
//    - In the first IDLE cycle: done=1, busy=0.
//  - stop=1 in RUN or BLANK: at the next edge FSM=IDLE, en=0, busy=0, no done pulse, code held.
//    - stop beats start if both are asserted together.
//    - start asserted while busy is ignored (no restart, no queueing).
//  - HOLD=1: the code advances every cycle, and BLANK is one cycle.
//  - Hold counter is $clog2(HOLD+1) bits. It clears on every code change and on every state entry.
//    It never wraps mid-hold.
//  - rst asserted mid-sweep: reset values take effect at the next edge regardless of state.
//  - done and wrap are never high together; done is never high while busy=1.
// STRUCTURE
//  - Shared package scan_pkg:
//    - state encoding (IDLE=2'd0, RUN=2'd1, BLANK=2'd2)
//    - DIR_UP/DIR_DOWN constants
//    - default WIDTH and HOLD
//  - One sub-module, hold_timer:
//    - parameter HOLD; inputs clk, rst, clear
//    - outputs tick, high on the last cycle of each hold period
//  - FSM and code register live in the top.
//  - Outputs connect straight to decoder D and En.
// TESTING
//  1. rst held 2 cycles -> code=0, en=0, busy=0, done=0, wrap=0.
//  2. HOLD=20, start with dir=0, continuous=0 ->
//     - code 0..15, each held exactly 20 cycles with en=1
//     - then 20 cycles en=0 with code=15
//     - then done=1 for one cycle, busy=0; 340 cycles from start to done.
//  3. dir=1, continuous=1 ->
//     - sequence 15..0
//     - wrap=1 for one cycle as code goes 0->15
//     - en never drops across the wrap; done never asserts.
//  4. stop pulsed while code=7 mid-hold ->
//     - next cycle en=0, busy=0, code=7, no done
//     - a subsequent start restarts from code 0.
//  5. start and stop high together in IDLE -> stays IDLE.
//     start pulsed at code=3 during RUN -> sweep continues unchanged.
//  6. HOLD=1 -> code changes every cycle, BLANK lasts 1 cycle, done 17 cycles after start.
//     rst asserted at code=9 -> all outputs return to reset values next cycle.

Source files
------------

// File: rtl/scan_pkg.sv
// rtl/scan_pkg.sv - shared types and defaults for the scan code sequencer
package scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_BLANK = 2'd2
  } state_t;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  localparam int DEFAULT_WIDTH = 4;
  localparam int DEFAULT_HOLD  = 20;

endpackage

// File: rtl/hold_timer.sv
// rtl/hold_timer.sv - hold period counter; tick marks the last cycle of each period
module hold_timer #(
  parameter int HOLD = 20
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  output logic tick_o
);

  localparam int CW = $clog2(HOLD + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(HOLD - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == LAST_CNT);

  // Restarting on tick keeps the counter from ever wrapping mid-hold.
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clear_i || tick_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/scan_code_sequencer.sv
// rtl/scan_code_sequencer.sv - sweeps decoder codes with per-code hold and a blank period
module scan_code_sequencer
  import scan_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int HOLD  = DEFAULT_HOLD
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic             continuous_i,
  input  logic             dir_i,
  output logic [WIDTH-1:0] code_o,
  output logic             en_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             wrap_o
);

  localparam logic [WIDTH-1:0] LAST = '1;

  state_t           state_q;
  logic [WIDTH-1:0] code_q;
  logic             en_q, busy_q, done_q, wrap_q;
  logic             dir_q, cont_q;
  logic             tick;
  logic [WIDTH-1:0] first_code, term_code;

  assign first_code = (dir_q == DIR_DOWN) ? LAST : '0;
  assign term_code  = (dir_q == DIR_DOWN) ? '0 : LAST;

  // Holding the timer clear in IDLE makes every RUN entry start a fresh period;
  // BLANK entry and code steps coincide with tick, which restarts it anyway.
  hold_timer #(.HOLD(HOLD)) u_hold_timer (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (state_q == ST_IDLE),
    .tick_o  (tick)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      code_q  <= '0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      wrap_q  <= 1'b0;
      dir_q   <= DIR_UP;
      cont_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      wrap_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (start_i && !stop_i) begin
            state_q <= ST_RUN;
            en_q    <= 1'b1;
            busy_q  <= 1'b1;
            dir_q   <= dir_i;
            cont_q  <= continuous_i;
            code_q  <= (dir_i == DIR_DOWN) ? LAST : '0;
          end
        end
        ST_RUN: begin
          if (stop_i) begin
            state_q <= ST_IDLE;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
          end else if (tick) begin
            if (code_q == term_code) begin
              if (cont_q) begin
                code_q <= first_code;
                wrap_q <= 1'b1;
              end else begin
                state_q <= ST_BLANK;
                en_q    <= 1'b0;
              end
            end else begin
              code_q <= (dir_q == DIR_DOWN) ? code_q - 1'b1 : code_q + 1'b1;
            end
          end
        end
        ST_BLANK: begin
          if (stop_i) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else if (tick) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          en_q    <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign code_o = code_q;
  assign en_o   = en_q;
  assign busy_o = busy_q;
  assign done_o = done_q;
  assign wrap_o = wrap_q;

endmodule

// File: tb/tb_scan_code_sequencer.sv
// tb/tb_scan_code_sequencer.sv - randomized bench for scan_code_sequencer, HOLD=20 and HOLD=1
module tb_scan_code_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic stop = 1'b0;
  logic continuous = 1'b0;
  logic dir = 1'b0;

  logic [3:0] code_w [2];
  logic       en_w   [2];
  logic       busy_w [2];
  logic       done_w [2];
  logic       wrap_w [2];

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  scan_code_sequencer #(.WIDTH(4), .HOLD(20)) u_h20 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .stop_i(stop),
    .continuous_i(continuous), .dir_i(dir),
    .code_o(code_w[0]), .en_o(en_w[0]), .busy_o(busy_w[0]),
    .done_o(done_w[0]), .wrap_o(wrap_w[0])
  );

  scan_code_sequencer #(.WIDTH(4), .HOLD(1)) u_h1 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .stop_i(stop),
    .continuous_i(continuous), .dir_i(dir),
    .code_o(code_w[1]), .en_o(en_w[1]), .busy_o(busy_w[1]),
    .done_o(done_w[1]), .wrap_o(wrap_w[1])
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask

  // Reference: a sweep is a position counter since RUN entry; code = position / HOLD.
  int   hold_c [2] = '{20, 1};
  bit   act   [2] = '{0, 0};
  int   pos   [2] = '{0, 0};
  bit   dl    [2] = '{0, 0};
  bit   cl    [2] = '{0, 0};
  bit   mdone [2] = '{0, 0};
  bit   mwrap [2] = '{0, 0};
  int   mcode [2] = '{0, 0};

  always @(posedge clk) begin
    int h, idx;
    for (int i = 0; i < 2; i++) begin
      h = hold_c[i];
      mdone[i] = 0;
      mwrap[i] = 0;
      if (rst) begin
        act[i] = 0; pos[i] = 0; mcode[i] = 0;
      end else if (act[i]) begin
        if (stop) begin
          act[i] = 0;
        end else begin
          pos[i]++;
          if (cl[i] && pos[i] == 16 * h) begin
            pos[i] = 0; mwrap[i] = 1;
          end else if (!cl[i] && pos[i] == 17 * h) begin
            act[i] = 0; mdone[i] = 1;
          end
        end
      end else if (start && !stop) begin
        act[i] = 1; pos[i] = 0; dl[i] = dir; cl[i] = continuous;
      end
      if (act[i]) begin
        idx = pos[i] / h;
        if (idx > 15) idx = 15;
        mcode[i] = dl[i] ? 15 - idx : idx;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      for (int i = 0; i < 2; i++) begin
        check_eq($sformatf("h%0d.code", hold_c[i]), 32'(code_w[i]), 32'(mcode[i]));
        check_eq($sformatf("h%0d.en", hold_c[i]), 32'(en_w[i]),
                 32'(act[i] && pos[i] < 16 * hold_c[i]));
        check_eq($sformatf("h%0d.busy", hold_c[i]), 32'(busy_w[i]), 32'(act[i]));
        check_eq($sformatf("h%0d.done", hold_c[i]), 32'(done_w[i]), 32'(mdone[i]));
        check_eq($sformatf("h%0d.wrap", hold_c[i]), 32'(wrap_w[i]), 32'(mwrap[i]));
      end
    end
  end

  // Returns at the first negedge after the start edge; dir/continuous are scrambled after to test latching.
  task automatic pulse_start(input logic d, input logic c);
    start = 1'b1; dir = d; continuous = c;
    @(negedge clk);
    start = 1'b0; dir = 1'($urandom); continuous = 1'($urandom);
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  initial begin
    int b0, b1, e0, d0, d1, w0, wd0;
    @(negedge clk);
    chk_on = 1'b1;
    @(negedge clk);
    check_eq("reset.code", 32'(code_w[0]), 32'd0);
    check_eq("reset.busy", 32'(busy_w[0]), 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Single up sweep: 340 busy cycles at HOLD=20, 17 at HOLD=1, one done pulse each.
    pulse_start(1'b0, 1'b0);
    b0 = 0; b1 = 0; e0 = 0; d0 = 0; d1 = 0;
    for (int k = 0; k < 400; k++) begin
      b0 += int'(busy_w[0]); b1 += int'(busy_w[1]); e0 += int'(en_w[0]);
      d0 += int'(done_w[0]); d1 += int'(done_w[1]);
      @(negedge clk);
    end
    check_eq("sweep20.busy_cycles", 32'(b0), 32'd340);
    check_eq("sweep20.en_cycles", 32'(e0), 32'd320);
    check_eq("sweep20.done_pulses", 32'(d0), 32'd1);
    check_eq("sweep1.busy_cycles", 32'(b1), 32'd17);
    check_eq("sweep1.done_pulses", 32'(d1), 32'd1);

    // Continuous down sweep: wraps at 320 and 640 cycles, en held, no done.
    pulse_start(1'b1, 1'b1);
    check_eq("down.first_code", 32'(code_w[0]), 32'd15);
    w0 = 0; wd0 = 0; e0 = 0;
    for (int k = 0; k < 700; k++) begin
      w0 += int'(wrap_w[0]); wd0 += int'(done_w[0]); e0 += int'(en_w[0]);
      @(negedge clk);
    end
    check_eq("cont.wraps", 32'(w0), 32'd2);
    check_eq("cont.dones", 32'(wd0), 32'd0);
    check_eq("cont.en_cycles", 32'(e0), 32'd700);
    pulse_stop();

    // Stop mid-hold at code 7, then restart from 0.
    repeat (3) @(negedge clk);
    pulse_start(1'b0, 1'b0);
    repeat (7 * 20 + 4) @(negedge clk);
    check_eq("stop.code_before", 32'(code_w[0]), 32'd7);
    pulse_stop();
    check_eq("stop.en_after", 32'(en_w[0]), 32'd0);
    check_eq("stop.code_after", 32'(code_w[0]), 32'd7);
    repeat (5) @(negedge clk);
    pulse_start(1'b0, 1'b0);
    check_eq("restart.code", 32'(code_w[0]), 32'd0);

    // Start while busy is ignored; start with stop in IDLE stays IDLE.
    repeat (3 * 20 + 2) @(negedge clk);
    pulse_start(1'b1, 1'b1);
    repeat (30) @(negedge clk);
    check_eq("busy_start.code", 32'(code_w[0]), 32'd4);
    pulse_stop();
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    check_eq("start_stop.busy", 32'(busy_w[0]), 32'd0);
    repeat (3) @(negedge clk);

    // Reset mid-sweep at HOLD=1 code 9.
    pulse_start(1'b0, 1'b0);
    repeat (9) @(negedge clk);
    check_eq("rst_mid.code_before", 32'(code_w[1]), 32'd9);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("rst_mid.code_after", 32'(code_w[1]), 32'd0);
    check_eq("rst_mid.busy_after", 32'(busy_w[1]), 32'd0);

    // Random traffic checked cycle by cycle against the reference.
    for (int k = 0; k < 5000; k++) begin
      start      = ($urandom_range(0, 15) == 0);
      stop       = ($urandom_range(0, 299) == 0);
      rst        = ($urandom_range(0, 1499) == 0);
      dir        = 1'($urandom);
      continuous = ($urandom_range(0, 3) == 0);
      @(negedge clk);
    end
    start = 1'b0; stop = 1'b0; rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
